// File: rtl/rr_req_gen_if.sv
// rr_req_gen_if: enqueue, scheduler (req/grant/stall) and dequeue signals of
// one requester slot. The master modport is the rr_req_gen side; the slave
// modport is the side that feeds enqueues, runs the scheduler and consumes
// dequeue commands.
interface rr_req_gen_if #(
  parameter int GSIZE     = 4,
  parameter int LOG_GSIZE = 2
);
  logic                 enq_valid;
  logic [LOG_GSIZE-1:0] enq_dst;
  logic                 enq_ready;
  logic [GSIZE-1:0]     req;
  logic                 stall;
  logic [GSIZE-1:0]     grant;
  logic                 deq_valid;
  logic [LOG_GSIZE-1:0] deq_dst;
  logic                 deq_ready;
  logic                 err;

  modport master (
    input  enq_valid, enq_dst, grant, deq_ready,
    output enq_ready, req, stall, deq_valid, deq_dst, err
  );

  modport slave (
    output enq_valid, enq_dst, grant, deq_ready,
    input  enq_ready, req, stall, deq_valid, deq_dst, err
  );
endinterface

// File: rtl/rr_req_gen.sv
// rr_req_gen: requester-side companion to one round-robin scheduler slot.
// Keeps a saturating pending-cell counter per destination, raises req for
// every non-empty destination, and turns each accepted grant into a
// registered dequeue command held until the cell buffer takes it.
// Optional macro RR_REQ_GRANT_CHK_EN: only exactly one-hot, requested grants
// are honoured; any other non-zero grant seen while not stalled sets a
// sticky err. Without it, err is 0 and the lowest requested grant bit wins.
module rr_req_gen #(
  parameter int GSIZE     = 4,
  parameter int LOG_GSIZE = 2,
  parameter int CNT_WIDTH = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  rr_req_gen_if.master bus
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [CNT_WIDTH-1:0] cnt [GSIZE];
  logic [GSIZE-1:0]     req_w;
  logic [GSIZE-1:0]     masked;
  logic [LOG_GSIZE-1:0] gnt_idx;
  logic                 gnt_legal;
  logic                 gnt_acc;
  logic                 enq_acc;
  logic                 enq_ready_w;
  logic                 stall_w;
  logic                 deq_valid_q;
  logic [LOG_GSIZE-1:0] deq_dst_q;

  // Full check uses the count before this cycle's update, so a same-cycle
  // grant to a full destination cannot make room for the enqueue.
  assign enq_ready_w = (cnt[bus.enq_dst] != CNT_MAX);
  assign enq_acc     = bus.enq_valid & enq_ready_w;
  assign stall_w     = deq_valid_q & ~bus.deq_ready;

  // Request vector straight from the registered counts.
  always_comb begin
    req_w = '0;
    for (int i = 0; i < GSIZE; i++) begin
      req_w[i] = (cnt[i] != '0);
    end
  end

  // Pick the granted destination: lowest set bit of the requested grant bits.
  always_comb begin
    masked  = bus.grant & req_w;
    gnt_idx = '0;
    for (int i = GSIZE - 1; i >= 0; i--) begin
      if (masked[i]) gnt_idx = LOG_GSIZE'(i);
    end
`ifdef RR_REQ_GRANT_CHK_EN
    gnt_legal = (bus.grant != '0) &&
                ((bus.grant & (bus.grant - GSIZE'(1))) == '0) &&
                (masked != '0);
`else
    gnt_legal = (masked != '0);
`endif
  end

  assign gnt_acc = gnt_legal & ~stall_w;

  // Per-destination pending counters; enqueue and dequeue to the same
  // destination in one cycle cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < GSIZE; i++) cnt[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < GSIZE; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < GSIZE; i++) begin
        if (enq_acc && (bus.enq_dst == LOG_GSIZE'(i)) &&
            !(gnt_acc && (gnt_idx == LOG_GSIZE'(i)))) begin
          if (cnt[i] != CNT_MAX) cnt[i] <= cnt[i] + 1'b1;
        end else if (gnt_acc && (gnt_idx == LOG_GSIZE'(i)) &&
                     !(enq_acc && (bus.enq_dst == LOG_GSIZE'(i)))) begin
          if (cnt[i] != '0) cnt[i] <= cnt[i] - 1'b1;
        end
      end
    end
  end

  // Dequeue command register: loads on an accepted grant (back-to-back with
  // a completing command), clears on completion, otherwise holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deq_valid_q <= 1'b0;
      deq_dst_q   <= '0;
    end else if (clr) begin
      deq_valid_q <= 1'b0;
      deq_dst_q   <= '0;
    end else if (gnt_acc) begin
      deq_valid_q <= 1'b1;
      deq_dst_q   <= gnt_idx;
    end else if (bus.deq_ready) begin
      deq_valid_q <= 1'b0;
    end
  end

`ifdef RR_REQ_GRANT_CHK_EN
  logic err_q;

  // Sticky flag for any non-zero grant that is not legal; stalled grants are
  // ignored without flagging.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (clr) begin
      err_q <= 1'b0;
    end else if (!stall_w && (bus.grant != '0) && !gnt_legal) begin
      err_q <= 1'b1;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.enq_ready = enq_ready_w;
  assign bus.req       = req_w;
  assign bus.stall     = stall_w;
  assign bus.deq_valid = deq_valid_q;
  assign bus.deq_dst   = deq_dst_q;

endmodule
